// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Holds default widths, port ids and the request record.
package ram_arb_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 3;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// Ports: eligible[1:0], ptr (last granted) -> grant (one-hot), next_ptr.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       next_ptr
);

  always_comb begin
    grant    = 2'b00;
    next_ptr = ptr;
    case (eligible)
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      // tie goes to the port that was not granted last
      2'b11: grant = (ptr == PORT1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    if (grant[1])
      next_ptr = PORT1;
    else if (grant[0])
      next_ptr = PORT0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter in front of a single-port 8x128 RAM.
// Ports: req/we/addr/wdata in and gnt/rvalid/rdata out for ports 0 and 1;
// mem_addr/mem_wr_en/mem_data_in to the RAM, mem_data_out back from it.
module ram_arbiter
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [1:0] eligible;
  logic [1:0] grant;
  logic       ptr;
  logic       next_ptr;
  logic       pend_valid;
  logic       pend_port;
  req_t       r0;
  req_t       r1;
  req_t       win;

  // a port on the bus this cycle is not re-sampled
  assign eligible = {req1 & ~gnt1, req0 & ~gnt0};

  assign r0  = '{we: we0, addr: addr0, wdata: wdata0};
  assign r1  = '{we: we1, addr: addr1, wdata: wdata1};
  assign win = grant[1] ? r1 : r0;

  rr_arb2 u_arb (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      ptr         <= PORT1;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_data_in <= '0;
      pend_valid  <= 1'b0;
      pend_port   <= PORT0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      gnt0 <= grant[0];
      gnt1 <= grant[1];
      ptr  <= next_ptr;
      if (|grant) begin
        mem_addr    <= win.addr;
        mem_wr_en   <= win.we;
        mem_data_in <= win.wdata;
      end else begin
        mem_wr_en <= 1'b0;
      end
      // read on the bus now -> RAM data arrives next cycle
      pend_valid <= (gnt0 | gnt1) & ~mem_wr_en;
      pend_port  <= gnt1 ? PORT1 : PORT0;
      rvalid0 <= pend_valid & (pend_port == PORT0);
      rvalid1 <= pend_valid & (pend_port == PORT1);
      if (pend_valid && pend_port == PORT0)
        rdata0 <= mem_data_out;
      if (pend_valid && pend_port == PORT1)
        rdata1 <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM.
// Checks are cycle-exact against hand-derived grant/rvalid timing.
module tb_ram_arbiter;

  logic         clk;
  logic         rst;
  logic         req0, we0, req1, we1;
  logic [2:0]   addr0, addr1;
  logic [127:0] wdata0, wdata1;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [127:0] rdata0, rdata1;
  logic [2:0]   mem_addr;
  logic         mem_wr_en;
  logic [127:0] mem_data_in, mem_data_out;

  logic [127:0] mem [8];

  int total = 0;
  int bad   = 0;

  ram_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt0         (gnt0),
    .gnt1         (gnt1),
    .rvalid0      (rvalid0),
    .rvalid1      (rvalid1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en)
      mem[mem_addr] <= mem_data_in;
    mem_data_out <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wr0(input logic [2:0] a, input logic [127:0] d);
    int n;
    req0 = 1; we0 = 1; addr0 = a; wdata0 = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gnt0 && n < 8);
    chk("wr0_gnt", {127'd0, gnt0}, 128'd1);
    req0 = 0;
  endtask

  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] K  = 128'h0101;

  initial begin
    logic [1:0] eg, er;
    int i0, i1, c0, c1, j;

    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_ctl", {gnt0, gnt1, rvalid0, rvalid1,
                       mem_wr_en, mem_addr}, 0);
      chk("idle_rd", rdata0 | rdata1, 0);
      chk("idle_wd", mem_data_in, 0);
    end

    // port 0 write then read of addr 3
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = A5;
    tick();
    chk("t2_gnt_w", {gnt0, gnt1, mem_wr_en}, 3'b101);
    chk("t2_addr", mem_addr, 3);
    chk("t2_wdata", mem_data_in, A5);
    we0 = 0;
    tick();
    chk("t2_gap", {gnt0, gnt1}, 0);
    tick();
    chk("t2_gnt_r", {gnt0, gnt1, mem_wr_en}, 3'b100);
    req0 = 0;
    tick();
    chk("t2_pend", {rvalid0, rvalid1}, 0);
    tick();
    chk("t2_rv", {rvalid0, rvalid1}, 2'b10);
    chk("t2_rd", rdata0, A5);
    tick();
    chk("t2_rv_off", {rvalid0, rvalid1}, 0);
    chk("t2_hold", rdata0, A5);

    // tie right after reset: port 0 first
    do_reset();
    req0 = 1; we0 = 1; addr0 = 1; wdata0 = 128'h11;
    req1 = 1; we1 = 0; addr1 = 1;
    tick();
    chk("t3_g0", {gnt0, gnt1, mem_wr_en}, 3'b101);
    req0 = 0;
    tick();
    chk("t3_g1", {gnt0, gnt1, mem_wr_en}, 3'b010);
    chk("t3_addr", mem_addr, 1);
    req1 = 0;
    tick();
    chk("t3_pend", {rvalid0, rvalid1}, 0);
    tick();
    chk("t3_rv", {rvalid0, rvalid1}, 2'b01);
    chk("t3_rd1", rdata1, 128'h11);
    chk("t3_rd0", rdata0, 0);

    // prefill, then both ports stream 8 reads each
    for (int a = 0; a < 8; a++)
      wr0(3'(a), 128'(a) * K);
    tick();
    do_reset();
    req0 = 1; we0 = 0; addr0 = 0;
    req1 = 1; we1 = 0; addr1 = 0;
    i0 = 0; i1 = 0; c0 = 0; c1 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      eg = (i <= 16) ? ((i % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("t4_gnt", {gnt0, gnt1}, eg);
      j = i - 2;
      er = (j >= 1 && j <= 16) ?
           ((j % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("t4_rv", {rvalid0, rvalid1}, er);
      if (rvalid0) begin
        chk("t4_rd0", rdata0, 128'(c0) * K);
        c0++;
      end
      if (rvalid1) begin
        chk("t4_rd1", rdata1, 128'(c1) * K);
        c1++;
      end
      if (gnt0) begin
        i0++;
        if (i0 < 8) addr0 = 3'(i0);
        else req0 = 0;
      end
      if (gnt1) begin
        i1++;
        if (i1 < 8) addr1 = 3'(i1);
        else req1 = 0;
      end
    end
    chk("t4_n0", 128'(c0), 8);
    chk("t4_n1", 128'(c1), 8);

    // lone port 1: every other cycle
    req1 = 1; we1 = 0; addr1 = 4;
    i1 = 0; c1 = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      eg = (i <= 7 && i % 2 == 1) ? 2'b01 : 2'b00;
      chk("t5_gnt", {gnt0, gnt1}, eg);
      j = i - 2;
      er = (j >= 1 && j <= 7 && j % 2 == 1) ? 2'b01 : 2'b00;
      chk("t5_rv", {rvalid0, rvalid1}, er);
      if (rvalid1) begin
        chk("t5_rd1", rdata1, 128'(4 + c1) * K);
        c1++;
      end
      if (gnt1) begin
        i1++;
        if (i1 < 4) addr1 = 3'(4 + i1);
        else req1 = 0;
      end
    end
    chk("t5_n1", 128'(c1), 4);

    // p1 write, p0 read of same address next cycle
    req1 = 1; we1 = 1; addr1 = 7; wdata1 = '1;
    tick();
    chk("t6_g1", {gnt0, gnt1, mem_wr_en}, 3'b011);
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 7;
    tick();
    chk("t6_g0", {gnt0, gnt1, mem_wr_en}, 3'b100);
    chk("t6_addr", mem_addr, 7);
    req0 = 0;
    tick();
    tick();
    chk("t6_rv", {rvalid0, rvalid1}, 2'b10);
    chk("t6_rd", rdata0, '1);

    // reset while a read is in flight
    req0 = 1; we0 = 0; addr0 = 3;
    tick();
    chk("t7_g0", {127'd0, gnt0}, 1);
    req0 = 0;
    tick();
    rst = 1;
    #1;
    chk("t7_ctl", {gnt0, gnt1, rvalid0, rvalid1,
                   mem_wr_en, mem_addr}, 0);
    chk("t7_rd", rdata0 | rdata1, 0);
    chk("t7_wd", mem_data_in, 0);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t7_norv", {rvalid0, rvalid1}, 0);
      chk("t7_rd0", rdata0, 0);
    end

    // reset cuts a write grant: no commit
    req0 = 1; we0 = 1; addr0 = 5; wdata0 = 128'hDEAD;
    tick();
    chk("t8_we", {gnt0, mem_wr_en}, 2'b11);
    rst = 1;
    #1;
    chk("t8_we_off", {gnt0, mem_wr_en}, 2'b00);
    tick();
    rst = 0;
    req0 = 1; we0 = 0; addr0 = 5;
    tick();
    chk("t8_g0", {gnt0, mem_wr_en}, 2'b10);
    req0 = 0;
    tick();
    tick();
    chk("t8_rv", {rvalid0, rvalid1}, 2'b10);
    chk("t8_rd", rdata0, 128'd5 * K);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter for the single-port `ram` (8 x 128-bit). Samples two independent request ports, issues at most one RAM access per cycle, and routes read data back to the issuing port with a fixed latency. Sits between the `ram` instance and its two client blocks, which never drive `ram` directly.

## Interface
- DATA_W, 128, width of data words
- ADDR_W, 3, RAM address width (2**ADDR_W entries)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  access request, held with its qualifiers until matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle grant pulse; access is on the RAM bus this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdataN holds this port's read result
- rdata0 / rdata1  out  DATA_W  last read result for the port, held until next rvalid
- mem_addr  out  ADDR_W  to `ram` addr
- mem_wr_en  out  1  to `ram` wr_en
- mem_data_in  out  DATA_W  to `ram` data_in
- mem_data_out  in  DATA_W  from `ram` data_out, valid one cycle after mem_addr is presented

## Operation
- Eligibility in cycle N: reqK high and gntK low in N (a port granted this cycle is not re-sampled; it updates or drops req at the end of the grant cycle).
- One eligible port: granted. Both eligible: port other than last-granted wins; last-granted pointer resets to port 1, so port 0 wins the first tie.
- Issue stage (registered): at the edge ending N, winner's gntK, mem_addr, mem_wr_en (= weK), mem_data_in (= wdataK) load; all appear in N+1. No winner: gnt low, mem_wr_en 0, mem_addr/mem_data_in hold.
- Write commits in `ram` at the edge ending N+1. No rvalid for writes.
- Read pipeline: pending stage records (valid, port) at edge ending N+1; at edge ending N+2 mem_data_out is captured into rdataK and rvalidK pulses in N+3. Other port's rdata unaffected.
- Ordering is grant order: a read granted the cycle after a write to the same address returns the new data.
- Throughput: one access per cycle with both ports active (alternating); one access per two cycles for a lone port.
- No FSM beyond the 3-stage pipeline (issue, pending, capture) and the 1-bit round-robin pointer.

## Timing
- Reset values: gnt0/1 = 0, rvalid0/1 = 0, rdata0/1 = 0, mem_addr = 0, mem_wr_en = 0, mem_data_in = 0, pointer = port 1, pipeline valids = 0.
- Latency: req sampled in N -> gnt in N+1 -> rvalid in N+3 (reads).
- Reset asserted mid-operation: all outputs return to reset values immediately; in-flight reads are dropped (no rvalid after reset); a write whose grant cycle is cut by reset does not commit (mem_wr_en forced 0).
- Requester changing addr/we/wdata while req high and before gnt: undefined; bench must not do it.
- mem_data_out is only sampled when the pending stage is valid with a read.

## Structure
- Package ram_arb_pkg: DATA_W/ADDR_W defaults, port-id constants PORT0/PORT1, request record typedef (we, addr, wdata).
- One sub-module: rr_arb2 (2-way round-robin picker: eligible[1:0], pointer -> one-hot grant, next pointer). Registers live in ram_arbiter.
- `ram` is instantiated by the parent, not inside this block.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles; assert rst mid-read -> no rvalid, rdata0/1 = 0.
- Port 0 writes 0xA5..A5 to addr 3, then reads addr 3 -> gnt0 one cycle after each req, rvalid0 three cycles after read req, rdata0 = 0xA5..A5.
- Both ports request from the first cycle after reset (p0 write addr 1 = 0x11, p1 read addr 1) -> gnt0 first, gnt1 next cycle, rdata1 = 0x11.
- Both ports hold req for 8 reads each (addr 0..7, pre-filled with addr*0x0101) -> grants alternate 0,1,0,1 with no idle bus cycle; each rdata matches its address.
- Port 1 alone issues 4 reads back-to-back -> gnt1 every other cycle, 4 rvalid1 pulses, rvalid0 never high.
- Write from p1 to addr 7 = 0xFF.., read from p0 to addr 7 granted next cycle -> rdata0 = 0xFF...
